// File: rtl/ysyx_23060184_mem_arbiter_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter: state codes, owner tags,
// timeout default and the byte-strobe encodings used by the LSU.
package ysyx_23060184_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2,
    ARB_RESP = 2'd3
  } arb_state_t;

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

  localparam int ARB_TIMEOUT = 255;
  localparam int ARB_CNT_W   = 8;

  localparam int WMASK_LENGTH = 4;
  localparam logic [WMASK_LENGTH-1:0] WRITE_WORD = 4'b1111;
  localparam logic [WMASK_LENGTH-1:0] WRITE_HALF = 4'b0011;
  localparam logic [WMASK_LENGTH-1:0] WRITE_BYTE = 4'b0001;

endpackage

// File: rtl/ysyx_23060184_arb_timer.sv
// Saturating cycle timer: clr restarts at zero, en counts up, expired flags
// that the count has reached LIMIT.
module ysyx_23060184_arb_timer #(
  parameter int CNT_W = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = (count_reg == CNT_W'(LIMIT));

endmodule

// File: rtl/ysyx_23060184_mem_arbiter.sv
// Single-outstanding memory arbiter between fetch (IFU) and load/store (LSU).
// LSU wins ties, but only LSU_STREAK times in a row while fetch is waiting.
module ysyx_23060184_mem_arbiter
  import ysyx_23060184_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LSU_STREAK = 4,
  parameter int TIMEOUT    = ARB_TIMEOUT
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                ifu_req_valid,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_req_ready,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rsp_data,
  output logic                ifu_rsp_err,
  input  logic                lsu_req_valid,
  input  logic                lsu_req_we,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_req_ready,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rsp_data,
  output logic                lsu_rsp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data,
  input  logic                mem_rsp_err
);

  localparam int WMASK_W  = DATA_W / 8;
  localparam int STREAK_W = $clog2(LSU_STREAK + 1);

  arb_state_t          state_reg, state_next;
  logic                owner_reg, owner_next;
  logic [STREAK_W-1:0] streak_reg;
  logic                mem_req_valid_reg, mem_we_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [DATA_W-1:0]   mem_wdata_reg;
  logic [WMASK_W-1:0]  mem_wmask_reg;
  logic [DATA_W-1:0]   rsp_data_reg, rsp_data_next;
  logic                rsp_err_next;
  logic                ifu_rsp_valid_reg, lsu_rsp_valid_reg;
  logic                ifu_rsp_err_reg, lsu_rsp_err_reg;
  logic                ifu_grant, lsu_grant;
  logic                timer_clr, timer_en, timer_expired;
  logic                streak_at_limit;

  assign streak_at_limit = (streak_reg == STREAK_W'(LSU_STREAK));

  ysyx_23060184_arb_timer #(
    .CNT_W (ARB_CNT_W),
    .LIMIT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    ifu_grant     = 1'b0;
    lsu_grant     = 1'b0;
    timer_clr     = 1'b0;
    timer_en      = 1'b0;
    rsp_data_next = rsp_data_reg;
    rsp_err_next  = 1'b0;
    case (state_reg)
      ARB_IDLE: begin
        if (lsu_req_valid && !(ifu_req_valid && streak_at_limit)) begin
          lsu_grant  = 1'b1;
          owner_next = OWNER_LSU;
          state_next = ARB_REQ;
        end else if (ifu_req_valid) begin
          ifu_grant  = 1'b1;
          owner_next = OWNER_IFU;
          state_next = ARB_REQ;
        end
      end
      ARB_REQ: begin
        if (mem_req_ready) begin
          timer_clr  = 1'b1;
          state_next = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        timer_en = 1'b1;
        // A real response beats a timeout landing on the same cycle.
        if (mem_rsp_valid) begin
          rsp_data_next = mem_rsp_data;
          rsp_err_next  = mem_rsp_err;
          state_next    = ARB_RESP;
        end else if (timer_expired) begin
          rsp_data_next = '0;
          rsp_err_next  = 1'b1;
          state_next    = ARB_RESP;
        end
      end
      ARB_RESP: state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg         <= ARB_IDLE;
      owner_reg         <= OWNER_IFU;
      streak_reg        <= '0;
      mem_req_valid_reg <= 1'b0;
      mem_we_reg        <= 1'b0;
      mem_addr_reg      <= '0;
      mem_wdata_reg     <= '0;
      mem_wmask_reg     <= '0;
      rsp_data_reg      <= '0;
      ifu_rsp_valid_reg <= 1'b0;
      lsu_rsp_valid_reg <= 1'b0;
      ifu_rsp_err_reg   <= 1'b0;
      lsu_rsp_err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      if (lsu_grant) begin
        // Streak only grows while fetch is actually being held off.
        streak_reg    <= ifu_req_valid ? streak_reg + 1'b1 : '0;
        mem_we_reg    <= lsu_req_we;
        mem_addr_reg  <= lsu_req_addr;
        mem_wdata_reg <= lsu_req_wdata;
        mem_wmask_reg <= lsu_req_wmask;
      end else if (ifu_grant) begin
        streak_reg    <= '0;
        mem_we_reg    <= 1'b0;
        mem_addr_reg  <= ifu_req_addr;
        mem_wdata_reg <= '0;
        mem_wmask_reg <= '0;
      end
      mem_req_valid_reg <= (state_next == ARB_REQ);
      rsp_data_reg      <= rsp_data_next;
      ifu_rsp_valid_reg <= (state_next == ARB_RESP) && (owner_next == OWNER_IFU);
      lsu_rsp_valid_reg <= (state_next == ARB_RESP) && (owner_next == OWNER_LSU);
      ifu_rsp_err_reg   <= (state_next == ARB_RESP) && (owner_next == OWNER_IFU) && rsp_err_next;
      lsu_rsp_err_reg   <= (state_next == ARB_RESP) && (owner_next == OWNER_LSU) && rsp_err_next;
    end
  end

  assign ifu_req_ready = ifu_grant;
  assign lsu_req_ready = lsu_grant;
  assign ifu_rsp_valid = ifu_rsp_valid_reg;
  assign ifu_rsp_data  = rsp_data_reg;
  assign ifu_rsp_err   = ifu_rsp_err_reg;
  assign lsu_rsp_valid = lsu_rsp_valid_reg;
  assign lsu_rsp_data  = rsp_data_reg;
  assign lsu_rsp_err   = lsu_rsp_err_reg;
  assign mem_req_valid = mem_req_valid_reg;
  assign mem_we        = mem_we_reg;
  assign mem_addr      = mem_addr_reg;
  assign mem_wdata     = mem_wdata_reg;
  assign mem_wmask     = mem_wmask_reg;

endmodule

// File: tb/tb_ysyx_23060184_mem_arbiter.sv
// Directed bench for the memory arbiter: transaction-timestamp model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_ysyx_23060184_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STREAK = 4;
  localparam int TMO    = 255;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
  logic [31:0] ifu_req_addr, ifu_rsp_data;
  logic        lsu_req_valid, lsu_req_we, lsu_req_ready, lsu_rsp_valid, lsu_rsp_err;
  logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_data;
  logic [3:0]  lsu_req_wmask;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid, mem_rsp_err;
  logic [31:0] mem_addr, mem_wdata, mem_rsp_data;
  logic [3:0]  mem_wmask;

  ysyx_23060184_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LSU_STREAK(STREAK), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_we(lsu_req_we), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask), .lsu_req_ready(lsu_req_ready),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory stub controls
  int          acc_delay = 0, rsp_delay = 0;
  logic [31:0] rsp_word = 32'h0;
  logic        rsp_bad = 1'b0, silent = 1'b0, spur = 1'b0;
  bit          mpend = 1'b0;
  int          mcnt = 0;

  initial begin
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
    forever begin
      @(posedge clk); #2;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
      if (!rstn) begin
        mpend = 1'b0; mcnt = 0;
      end else if (spur) begin
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD0BAD0; spur = 1'b0;
      end else if (mem_req_valid && !mpend) begin
        if (mcnt >= acc_delay) begin mem_req_ready = 1'b1; mpend = 1'b1; mcnt = 0; end
        else mcnt++;
      end else if (mpend) begin
        if (mcnt >= rsp_delay) begin
          if (!silent) begin mem_rsp_valid = 1'b1; mem_rsp_data = rsp_word; mem_rsp_err = rsp_bad; end
          mpend = 1'b0; mcnt = 0;
        end else mcnt++;
      end
    end
  end

  // Model: a transaction is a grant cycle, an accept cycle, a response cycle
  // and a pulse cycle one later; the arbiter is free again after the pulse.
  int          cyc = 0;
  bit          m_busy = 0, m_acc = 0, m_lsu = 0, m_we = 0, m_err = 0;
  int          m_wait = 0, m_due = -1, m_streak = 0;
  logic [31:0] m_addr, m_wdata, m_data;
  logic [3:0]  m_wmask;

  // Observations of the DUT used by the scenario checks
  logic [7:0]  gq[$];
  int          pulse_cnt = 0, acc_cnt = 0, last_grant = 0, last_acc = 0, last_pulse = 0;
  logic [31:0] last_data = '0;
  logic        last_err = 1'b0, last_lsu = 1'b0;
  logic [3:0]  last_wmask = '0;

  always @(negedge clk) begin
    bit g_l, g_i, e_mv, e_iv, e_lv;
    if (!rstn) begin
      m_busy = 0; m_acc = 0; m_wait = 0; m_due = -1; m_streak = 0;
      chk("rst_ifu_ready", ifu_req_ready, 0);
      chk("rst_lsu_ready", lsu_req_ready, 0);
      chk("rst_mem_req_valid", mem_req_valid, 0);
      chk("rst_ifu_rsp_valid", ifu_rsp_valid, 0);
      chk("rst_lsu_rsp_valid", lsu_rsp_valid, 0);
      chk("rst_errs", {ifu_rsp_err, lsu_rsp_err}, 0);
      chk("rst_mem_fields", {mem_we, mem_addr, mem_wmask}, 0);
      chk("rst_rsp_data", ifu_rsp_data, 0);
    end else begin
      g_l = 0; g_i = 0;
      if (!m_busy) begin
        if (lsu_req_valid && !(ifu_req_valid && m_streak == STREAK)) g_l = 1;
        else if (ifu_req_valid) g_i = 1;
      end
      e_mv = m_busy && !m_acc;
      e_iv = m_busy && (m_due == cyc) && !m_lsu;
      e_lv = m_busy && (m_due == cyc) && m_lsu;
      chk("ifu_req_ready", ifu_req_ready, g_i);
      chk("lsu_req_ready", lsu_req_ready, g_l);
      chk("mem_req_valid", mem_req_valid, e_mv);
      chk("ifu_rsp_valid", ifu_rsp_valid, e_iv);
      chk("lsu_rsp_valid", lsu_rsp_valid, e_lv);
      if (e_mv) begin
        chk("mem_we", mem_we, m_we);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("mem_wmask", mem_wmask, m_wmask);
      end
      if (e_iv) begin
        chk("ifu_rsp_data", ifu_rsp_data, m_data);
        chk("ifu_rsp_err", ifu_rsp_err, m_err);
      end
      if (e_lv) begin
        chk("lsu_rsp_err", lsu_rsp_err, m_err);
        if (!m_we) chk("lsu_rsp_data", lsu_rsp_data, m_data);
      end

      if (lsu_req_ready) begin gq.push_back(8'h4C); last_grant = cyc; end
      if (ifu_req_ready) begin gq.push_back(8'h49); last_grant = cyc; end
      if (mem_req_valid && mem_req_ready) begin
        acc_cnt++; last_acc = cyc;
        if (mem_we) last_wmask = mem_wmask;
      end
      if (ifu_rsp_valid || lsu_rsp_valid) begin
        pulse_cnt++; last_pulse = cyc; last_lsu = lsu_rsp_valid;
        last_data = lsu_rsp_valid ? lsu_rsp_data : ifu_rsp_data;
        last_err  = lsu_rsp_valid ? lsu_rsp_err : ifu_rsp_err;
      end

      if (g_l || g_i) begin
        m_busy = 1; m_acc = 0; m_wait = 0; m_due = -1; m_lsu = g_l;
        if (g_l) begin
          m_we = lsu_req_we; m_addr = lsu_req_addr; m_wdata = lsu_req_wdata; m_wmask = lsu_req_wmask;
          m_streak = ifu_req_valid ? m_streak + 1 : 0;
        end else begin
          m_we = 0; m_addr = ifu_req_addr; m_wdata = '0; m_wmask = '0; m_streak = 0;
        end
      end else if (m_busy && !m_acc) begin
        if (mem_req_ready) m_acc = 1;
      end else if (m_busy && m_due < 0) begin
        if (mem_rsp_valid) begin m_due = cyc + 1; m_data = mem_rsp_data; m_err = mem_rsp_err; end
        else if (m_wait == TMO) begin m_due = cyc + 1; m_data = '0; m_err = 1; end
        else m_wait++;
      end else if (m_busy && m_due == cyc) begin
        m_busy = 0;
      end
    end
    cyc++;
  end

  task automatic ifu_fetch(input logic [31:0] a);
    @(posedge clk); #1;
    ifu_req_valid = 1'b1; ifu_req_addr = a;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (ifu_req_ready) break; end
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
  endtask

  task automatic lsu_op(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm);
    @(posedge clk); #1;
    lsu_req_valid = 1'b1; lsu_req_we = we; lsu_req_addr = a; lsu_req_wdata = wd; lsu_req_wmask = wm;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (lsu_req_ready) break; end
    @(posedge clk); #1;
    lsu_req_valid = 1'b0;
  endtask

  task automatic wait_pulses(input int target, input int bound, input string nm);
    for (int i = 0; i < bound && pulse_cnt < target; i++) begin @(negedge clk); #1; end
    chk(nm, pulse_cnt, target);
  endtask

  initial begin
    int p0, a0;
    string es;
    bit di, dl;
    rstn = 1'b0;
    ifu_req_valid = 0; ifu_req_addr = '0;
    lsu_req_valid = 0; lsu_req_we = 0; lsu_req_addr = '0; lsu_req_wdata = '0; lsu_req_wmask = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);

    // 1: IFU alone, response one cycle after accept
    acc_delay = 0; rsp_delay = 1; rsp_word = 32'h00000413; rsp_bad = 0;
    p0 = pulse_cnt;
    ifu_fetch(32'h80000000);
    wait_pulses(p0 + 1, 30, "t1_pulse_seen");
    chk("t1_data", last_data, 32'h00000413);
    chk("t1_err", last_err, 0);
    chk("t1_owner_ifu", last_lsu, 0);
    chk("t1_latency", last_pulse - last_grant, 4);
    $display("txn t1: ifu fetch 0x80000000 data=0x%08h err=%0d latency=%0d", last_data, last_err, last_pulse - last_grant);

    // 2: simultaneous requests, LSU store wins first
    rsp_delay = 0; rsp_word = 32'h11112222;
    gq.delete(); p0 = pulse_cnt;
    @(posedge clk); #1;
    ifu_req_valid = 1; ifu_req_addr = 32'h80000004;
    lsu_req_valid = 1; lsu_req_we = 1; lsu_req_addr = 32'h80001000;
    lsu_req_wdata = 32'hDEADBEEF; lsu_req_wmask = 4'b0011;
    for (int i = 0; i < 40 && (ifu_req_valid || lsu_req_valid); i++) begin
      @(negedge clk); di = ifu_req_ready; dl = lsu_req_ready;
      @(posedge clk); #1;
      if (di) ifu_req_valid = 0;
      if (dl) lsu_req_valid = 0;
    end
    wait_pulses(p0 + 2, 30, "t2_pulses_seen");
    chk("t2_first_grant", gq[0], 8'h4C);
    chk("t2_second_grant", gq[1], 8'h49);
    chk("t2_wmask", last_wmask, 4'b0011);
    $display("txn t2: store then fetch, grants=%0d wmask=%b", gq.size(), last_wmask);

    // 3: both held, streak limit forces a fetch every fifth grant
    gq.delete();
    @(posedge clk); #1;
    ifu_req_valid = 1; ifu_req_addr = 32'h80000008;
    lsu_req_valid = 1; lsu_req_we = 0; lsu_req_addr = 32'h80003000; lsu_req_wmask = '0;
    for (int i = 0; i < 300 && gq.size() < 10; i++) begin @(negedge clk); #1; end
    @(posedge clk); #1;
    ifu_req_valid = 0; lsu_req_valid = 0;
    repeat (10) @(posedge clk);
    es = "LLLLILLLLI";
    for (int i = 0; i < 10; i++) chk("t3_grant_order", gq[i], es[i]);
    $display("txn t3: first ten grants checked against %s", es);

    // 4: memory accepts but never answers -> timeout error
    silent = 1; p0 = pulse_cnt;
    ifu_fetch(32'h8000000C);
    wait_pulses(p0 + 1, 400, "t4_pulse_seen");
    chk("t4_err", last_err, 1);
    chk("t4_data", last_data, 0);
    chk("t4_accept_to_rsp", last_pulse - last_acc, TMO + 2);
    $display("txn t4: timeout err=%0d data=0x%08h after %0d cycles", last_err, last_data, last_pulse - last_acc);
    silent = 0;

    // 5: load with bus error, then a stray response while idle
    rsp_word = 32'h12345678; rsp_bad = 1; p0 = pulse_cnt;
    lsu_op(1'b0, 32'h80002000, 32'h0, 4'b0000);
    wait_pulses(p0 + 1, 30, "t5_pulse_seen");
    chk("t5_lsu_owner", last_lsu, 1);
    chk("t5_lsu_err", last_err, 1);
    rsp_bad = 0;
    repeat (2) @(posedge clk);
    p0 = pulse_cnt;
    spur = 1;
    repeat (6) @(posedge clk);
    chk("t5_no_spurious_pulse", pulse_cnt, p0);
    $display("txn t5: load err=%0d, stray response pulses=%0d", last_err, pulse_cnt - p0);

    // 6: reset during WAIT, late memory response afterwards
    silent = 1; a0 = acc_cnt;
    ifu_fetch(32'h80000010);
    for (int i = 0; i < 30 && acc_cnt == a0; i++) begin @(negedge clk); #1; end
    chk("t6_accepted", acc_cnt, a0 + 1);
    repeat (3) @(posedge clk);
    p0 = pulse_cnt;
    #1 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1; silent = 0; spur = 1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("t6_no_pulse", pulse_cnt, p0);
    chk("t6_outputs_idle", {mem_req_valid, ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_data}, 0);
    $display("txn t6: reset mid-wait, pulses after reset=%0d", pulse_cnt - p0);

    // recovery fetch after reset
    rsp_delay = 0; rsp_word = 32'hCAFE0013; p0 = pulse_cnt;
    ifu_fetch(32'h80000014);
    wait_pulses(p0 + 1, 30, "t7_pulse_seen");
    chk("t7_data", last_data, 32'hCAFE0013);
    chk("t7_latency", last_pulse - last_grant, 3);
    $display("txn t7: fetch after reset data=0x%08h latency=%0d", last_data, last_pulse - last_grant);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
